// File: rtl/l2_data_array.sv
// Single-port L2 cache data store: byte-masked writes, write-first registered read,
// and a zeroing sweep that runs after reset and whenever clear is requested.
module l2_data_array #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  output logic               ready,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   index,
  input  logic [WIDTH/8-1:0] wmask,
  input  logic [WIDTH-1:0]   datain,
  output logic [WIDTH-1:0]   dataout,
  output logic               rvalid
);

  localparam int BYTES = WIDTH / 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               rvalid_q, rvalid_d;
  logic [WIDTH-1:0]   dataout_q, dataout_d;

  // Storage deliberately has no reset; the sweep is what clears it.
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               accept;
  logic               rd_fire;
  logic               wr_fire;
  logic [WIDTH-1:0]   cur_line;
  logic [WIDTH-1:0]   merged_line;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_addr;
  logic [BYTES-1:0]   mem_be;
  logic [WIDTH-1:0]   mem_wdata;

  assign accept   = (state_q == ST_READY);
  assign rd_fire  = accept && rd_en;
  assign wr_fire  = accept && wr_en;
  assign cur_line = mem[index];

  // Write-first: the line a read returns already carries this cycle's enabled bytes.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
      assign merged_line[8*gi +: 8] = (wr_en && wmask[gi]) ? datain[8*gi +: 8]
                                                            : cur_line[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = index;
    mem_be    = wmask;
    mem_wdata = datain;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rvalid_d  = rd_fire;
    dataout_d = rd_fire ? merged_line : dataout_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        // An access in the same cycle as clear still completes; the sweep overwrites it.
        if (clear) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      rvalid_q  <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rvalid_q  <= rvalid_d;
      dataout_q <= dataout_d;
    end
  end

  assign ready   = (state_q == ST_READY);
  assign rvalid  = rvalid_q;
  assign dataout = dataout_q;

endmodule

// File: tb/tb_l2_data_array.sv
// Directed scoreboard bench for l2_data_array: expected read lines are queued when a
// request is driven and compared when rvalid should appear.
module tb_l2_data_array;

  localparam int WIDTH = 256;
  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BYTES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic             rd_en = 1'b0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] index = '0;
  logic [BYTES-1:0] wmask = '0;
  logic [WIDTH-1:0] datain = '0;
  logic             ready;
  logic             rvalid;
  logic [WIDTH-1:0] dataout;

  always #5 clk = ~clk;

  l2_data_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .ready   (ready),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .index   (index),
    .wmask   (wmask),
    .datain  (datain),
    .dataout (dataout),
    .rvalid  (rvalid)
  );

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_dataout = '0;
  logic             exp_rvalid = 1'b0;
  int               sweep_left = DEPTH;
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_step = 0;

  function automatic logic [WIDTH-1:0] fill(input logic [7:0] b);
    return {BYTES{b}};
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the reference model advances alongside and the outputs
  // are checked 1 time unit after the edge.
  task automatic step(input string tag, input logic c, input logic rd, input logic wr,
                      input int idx, input logic [BYTES-1:0] m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] line;
    clear  = c;
    rd_en  = rd;
    wr_en  = wr;
    index  = IDX_W'(idx);
    wmask  = m;
    datain = d;
    if (sweep_left > 0) begin
      model[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      line = model[idx];
      if (wr) begin
        for (int b = 0; b < BYTES; b++) begin
          if (m[b]) line[8*b +: 8] = d[8*b +: 8];
        end
        model[idx] = line;
      end
      if (rd) exp_q.push_back(line);
      if (c) sweep_left = DEPTH;
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (exp_q.size() > 0) begin
      exp_dataout = exp_q.pop_front();
      exp_rvalid  = 1'b1;
    end else begin
      exp_rvalid  = 1'b0;
    end
    n_step++;
    chk({tag, "_ready"}, WIDTH'(ready), WIDTH'(sweep_left == 0));
    chk({tag, "_rvalid"}, WIDTH'(rvalid), WIDTH'(exp_rvalid));
    chk({tag, "_dataout"}, dataout, exp_dataout);
    $display("step %0d %s clr=%b rd=%b wr=%b idx=%0d ready=%b rvalid=%b dataout=%h",
             n_step, tag, c, rd, wr, idx, ready, rvalid, dataout);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_ready"}, WIDTH'(ready), '0);
    chk({tag, "_async_rvalid"}, WIDTH'(rvalid), '0);
    chk({tag, "_async_dataout"}, dataout, '0);
    exp_q.delete();
    exp_dataout = '0;
    exp_rvalid  = 1'b0;
    sweep_left  = DEPTH;
    @(posedge clk);
    #1;
    chk({tag, "_held_ready"}, WIDTH'(ready), '0);
    rst_n = 1'b1;
    $display("reset %s released", tag);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) step(tag, 1'b0, 1'b1, 1'b0, i, '0, '0);
    step({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;

    // Power-on reset and first sweep; accesses during the sweep must be dropped.
    async_reset("por");
    for (int i = 0; i < DEPTH; i++)
      step("sweep0", 1'b0, i[0], (i % 3) == 0, i, '1, fill(8'hEE));
    read_all("rd_zero");

    // Byte-masked partial write over a full write.
    step("wr5_full", 1'b0, 1'b0, 1'b1, 5, '1, fill(8'hA5));
    d = '0;
    d[7:0] = 8'h3C;
    step("wr5_byte0", 1'b0, 1'b0, 1'b1, 5, BYTES'(1), d);
    step("rd5", 1'b0, 1'b1, 1'b0, 5, '0, '0);
    d = fill(8'hA5);
    d[7:0] = 8'h3C;
    chk("rd5_const", dataout, d);

    // Write-first read-during-write, then a zero-mask access.
    step("rdwr3", 1'b0, 1'b1, 1'b1, 3, '1, fill(8'hFF));
    chk("rdwr3_const", dataout, fill(8'hFF));
    step("mask0_3", 1'b0, 1'b1, 1'b1, 3, '0, fill(8'h00));
    step("rd3", 1'b0, 1'b1, 1'b0, 3, '0, '0);
    step("idle", 1'b0, 1'b0, 1'b0, 0, '0, '0);

    // Fill all lines, then clear together with a write+read of index 7.
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b0, 1'b0, 1'b1, i, '1, fill(8'(i * 16 + 1)));
    read_all("rd_fill");
    step("clr_wr7", 1'b1, 1'b1, 1'b1, 7, '1, fill(8'h77));
    for (int i = 0; i < DEPTH; i++)
      step("clr_sweep", (i == 4), 1'b1, 1'b1, i, '1, fill(8'h99));
    read_all("rd_cleared");

    // Reset in the middle of a clear sweep.
    for (int i = 0; i < DEPTH; i++)
      step("fill2", 1'b0, 1'b0, 1'b1, i, '1, fill(8'(8'hC0 + i)));
    step("clr2", 1'b1, 1'b0, 1'b0, 0, '0, '0);
    for (int i = 0; i < 9; i++) step("sweep_part", 1'b0, 1'b0, 1'b0, 0, '0, '0);
    async_reset("mid_sweep");
    for (int i = 0; i < DEPTH; i++) step("sweep_rst", 1'b0, 1'b1, 1'b0, i, '0, '0);
    read_all("rd_rst_sweep");

    // Reset while a read result is being presented.
    step("wr2", 1'b0, 1'b0, 1'b1, 2, '1, fill(8'h5A));
    step("rd2", 1'b0, 1'b1, 1'b0, 2, '0, '0);
    async_reset("mid_read");
    for (int i = 0; i < DEPTH; i++) step("sweep_rd", 1'b0, 1'b0, 1'b0, 0, '0, '0);
    step("rd2_after", 1'b0, 1'b1, 1'b0, 2, '0, '0);
    step("idle_end", 1'b0, 1'b0, 1'b0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
